bcd2bin: RTL and testbench

BCD2BIN -- requirements
Module: bcd2bin

---
 rtl/bcd2bin_pkg.sv | 23 ++
 rtl/bcd2bin.sv | 115 +++++++++++
 tb/tb_bcd2bin.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/bcd2bin_pkg.sv
// Shared state types for the BCD <-> binary converters.
// Both FSM encodings live here so every converter imports the same package.
package bcd2bin_pkg;

  typedef enum logic [2:0] {
    IDLE              = 3'd0,
    SHIFT             = 3'd1,
    CHECK_SHIFT_INDEX = 3'd2,
    SUB               = 3'd3,
    CHECK_DIGIT_INDEX = 3'd4,
    BIN_DONE          = 3'd5
  } bcd2bin_state_t;

  typedef enum logic [1:0] {
    B2D_IDLE  = 2'd0,
    B2D_SHIFT = 2'd1,
    B2D_ADD   = 2'd2,
    B2D_DONE  = 2'd3
  } bin2bcd_state_t;

  localparam int BCD2BIN_LOOP_W = 8;

endpackage

// File: rtl/bcd2bin.sv
// Sequential BCD to binary converter using reverse double dabble.
// One shift or one digit correction per clock; latency is data-independent.
module bcd2bin
  import bcd2bin_pkg::*;
#(
  parameter int BIN_WIDTH  = 8,
  parameter int DEC_DIGITS = 2
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic [DEC_DIGITS*4-1:0] DataBCD,
  input  logic                    Start,
  output logic [BIN_WIDTH-1:0]    DataBin,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Error,
  output bcd2bin_state_t          DbgState
);

  // Handshake: Start is a request sampled only while IDLE (Busy=0); Done is a
  // one-cycle valid pulse, with DataBin/Error holding their value until the next Done.

  localparam int BCD_W = DEC_DIGITS * 4;
  localparam int DIW   = $clog2(DEC_DIGITS) + 1;
  localparam logic [BCD2BIN_LOOP_W-1:0] LC_LAST = BCD2BIN_LOOP_W'(BIN_WIDTH - 1);
  localparam logic [DIW-1:0]            DI_LAST = DIW'(DEC_DIGITS - 1);

  bcd2bin_state_t              state_q;
  logic [BCD_W-1:0]            bcd_q;
  logic [BIN_WIDTH-1:0]        bin_q;
  logic [BCD2BIN_LOOP_W-1:0]   loop_count_q;
  logic [DIW-1:0]              digit_idx_q;
  logic                        invalid_q;

  logic [3:0] cur_digit;
  logic [3:0] corr_digit_d;
  logic       bad_digit_d;
  logic       conv_err_d;

  assign cur_digit    = bcd_q[digit_idx_q*4 +: 4];
  assign corr_digit_d = (cur_digit > 4'd7) ? (cur_digit - 4'd3) : cur_digit;
  // Leftover BCD after all shifts means the value did not fit in BIN_WIDTH bits.
  assign conv_err_d   = invalid_q | (|bcd_q);

  always_comb begin
    bad_digit_d = 1'b0;
    for (int i = 0; i < DEC_DIGITS; i++) begin
      if (DataBCD[i*4 +: 4] > 4'd9) bad_digit_d = 1'b1;
    end
  end

  assign Busy     = (state_q != IDLE);
  assign DbgState = state_q;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q      <= IDLE;
      bcd_q        <= '0;
      bin_q        <= '0;
      loop_count_q <= '0;
      digit_idx_q  <= '0;
      invalid_q    <= 1'b0;
      DataBin      <= '0;
      Done         <= 1'b0;
      Error        <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start) begin
            bcd_q     <= DataBCD;
            bin_q     <= '0;
            invalid_q <= bad_digit_d;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          bin_q   <= {bcd_q[0], bin_q[BIN_WIDTH-1:1]};
          bcd_q   <= {1'b0, bcd_q[BCD_W-1:1]};
          state_q <= CHECK_SHIFT_INDEX;
        end
        CHECK_SHIFT_INDEX: begin
          if (loop_count_q == LC_LAST) begin
            loop_count_q <= '0;
            state_q      <= BIN_DONE;
          end else begin
            loop_count_q <= loop_count_q + BCD2BIN_LOOP_W'(1);
            state_q      <= SUB;
          end
        end
        SUB: begin
          bcd_q[digit_idx_q*4 +: 4] <= corr_digit_d;
          state_q                   <= CHECK_DIGIT_INDEX;
        end
        CHECK_DIGIT_INDEX: begin
          if (digit_idx_q == DI_LAST) begin
            digit_idx_q <= '0;
            state_q     <= SHIFT;
          end else begin
            digit_idx_q <= digit_idx_q + DIW'(1);
            state_q     <= SUB;
          end
        end
        BIN_DONE: begin
          Done    <= 1'b1;
          Error   <= conv_err_d;
          DataBin <= conv_err_d ? '0 : bin_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin.sv
// Directed bench for bcd2bin: default (2-digit) and 3-digit instances.
// Expected results and Done cycles are queued at Start; monitors pop on Done.
module tb_bcd2bin;
  import bcd2bin_pkg::*;

  localparam int LAT2 = 45;
  localparam int LAT3 = 59;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // default instance
  logic [7:0]     data2;
  logic           start2;
  logic [7:0]     bin2;
  logic           busy2, done2, err2;
  bcd2bin_state_t st2;

  bcd2bin #(.BIN_WIDTH(8), .DEC_DIGITS(2)) dut2 (
    .Clk(clk), .Rst_n(rst_n), .DataBCD(data2), .Start(start2),
    .DataBin(bin2), .Busy(busy2), .Done(done2), .Error(err2), .DbgState(st2)
  );

  // three-digit instance
  logic [11:0]    data3;
  logic           start3;
  logic [7:0]     bin3;
  logic           busy3, done3, err3;
  bcd2bin_state_t st3;

  bcd2bin #(.BIN_WIDTH(8), .DEC_DIGITS(3)) dut3 (
    .Clk(clk), .Rst_n(rst_n), .DataBCD(data3), .Start(start3),
    .DataBin(bin3), .Busy(busy3), .Done(done3), .Error(err3), .DbgState(st3)
  );

  // scoreboard: {done cycle, error, result}
  logic [40:0] exp_q[$];
  logic [40:0] exp3_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    logic [40:0] e;
    if (done2 === 1'b1) begin
      if (exp_q.size() == 0) flag("d2_unexpected_done");
      else begin
        e = exp_q.pop_front();
        check("d2_bin",   32'(bin2), 32'(e[7:0]));
        check("d2_err",   32'(err2), 32'(e[8]));
        check("d2_cycle", cyc,       e[40:9]);
      end
    end
  end

  always @(negedge clk) begin
    logic [40:0] e;
    if (done3 === 1'b1) begin
      if (exp3_q.size() == 0) flag("d3_unexpected_done");
      else begin
        e = exp3_q.pop_front();
        check("d3_bin",   32'(bin3), 32'(e[7:0]));
        check("d3_err",   32'(err3), 32'(e[8]));
        check("d3_cycle", cyc,       e[40:9]);
      end
    end
  end

  // driver tasks: called right after a negedge, Start is sampled at the next posedge
  task automatic issue2(input logic [7:0] d, input logic e, input logic [7:0] b);
    data2  = d;
    start2 = 1'b1;
    exp_q.push_back({32'(cyc + 1 + LAT2), e, b});
    @(negedge clk);
    start2 = 1'b0;
  endtask

  task automatic issue3(input logic [11:0] d, input logic e, input logic [7:0] b);
    data3  = d;
    start3 = 1'b1;
    exp3_q.push_back({32'(cyc + 1 + LAT3), e, b});
    @(negedge clk);
    start3 = 1'b0;
  endtask

  task automatic wait_empty2();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      flag("d2_done_timeout");
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_empty3();
    for (int i = 0; i < 200 && exp3_q.size() != 0; i++) @(negedge clk);
    if (exp3_q.size() != 0) begin
      flag("d3_done_timeout");
      exp3_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    start2 = 1'b0;
    start3 = 1'b0;
    data2  = '0;
    data3  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    check("rst_bin",  32'(bin2),  32'h0);
    check("rst_done", 32'(done2), 32'h0);
    check("rst_err",  32'(err2),  32'h0);
    check("rst_busy", 32'(busy2), 32'h0);
    check("rst_busy3", 32'(busy3), 32'h0);

    @(negedge clk);
    issue2(8'h99, 1'b0, 8'h63);
    repeat (4) @(negedge clk);
    check("busy_during", 32'(busy2), 32'h1);
    wait_empty2();
    check("busy_after", 32'(busy2), 32'h0);
    repeat (3) @(negedge clk);
    check("bin_held", 32'(bin2), 32'h63);

    issue2(8'h00, 1'b0, 8'h00); wait_empty2();
    issue2(8'h42, 1'b0, 8'h2A); wait_empty2();
    issue2(8'h1A, 1'b1, 8'h00); wait_empty2();
    check("err_held", 32'(err2), 32'h1);
    issue2(8'h25, 1'b0, 8'h19); wait_empty2();

    // Start pulses mid-conversion must be ignored; restart right after Done
    issue2(8'h37, 1'b0, 8'h25);
    repeat (8) @(negedge clk);
    data2 = 8'h11; start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    repeat (19) @(negedge clk);
    data2 = 8'h11; start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    for (int i = 0; i < 100 && done2 !== 1'b1; i++) @(negedge clk);
    if (done2 !== 1'b1) flag("ign_no_done");
    issue2(8'h64, 1'b0, 8'h40);
    wait_empty2();

    // reset mid-conversion aborts with no Done
    issue2(8'h88, 1'b0, 8'h58);
    repeat (18) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    check("mrst_bin",  32'(bin2),  32'h0);
    check("mrst_done", 32'(done2), 32'h0);
    check("mrst_err",  32'(err2),  32'h0);
    check("mrst_busy", 32'(busy2), 32'h0);
    repeat (60) @(negedge clk);
    issue2(8'h88, 1'b0, 8'h58); wait_empty2();

    // three-digit instance: range limit and overflow
    issue3(12'h255, 1'b0, 8'hFF); wait_empty3();
    issue3(12'h256, 1'b1, 8'h00); wait_empty3();
    issue3(12'h128, 1'b0, 8'h80); wait_empty3();
    issue3(12'h999, 1'b1, 8'h00); wait_empty3();
    issue3(12'h000, 1'b0, 8'h00); wait_empty3();

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
